// File: rtl/async_mem_rr_scheduler.sv
// async_mem_rr_scheduler
//   Round-robin scheduler that lets three requesters share one asynchronous memory port.
//   Writes complete on acceptance. A read holds the memory port until out_valid returns.
//   Only one read may be outstanding at a time.
//
// Ports
//   clock, reset             clock; synchronous active-high reset
//   in_n_rd/wr/addr/din      requester n (n = 0..2) request and write data
//   in_n_dout                read data; always equal to out_dout
//   in_n_wait_n              high when requester n's request is (or would be) accepted
//   in_n_valid               read-data strobe, raised only for the owner of the pending read
//   out_rd/wr/addr/din       request forwarded to memory
//   out_dout                 read data returned by memory
//   out_wait_n, out_valid    memory accept / read-data strobe
//   busy                     a read is outstanding
//   timeout_err              one-cycle pulse when an outstanding read is aborted
//
// Build option
//   ASYNC_MEM_TIMEOUT_EN     compiles in a read watchdog that aborts a read left
//                            outstanding for TIMEOUT cycles
module async_mem_rr_scheduler #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_0_rd,
  input  logic                  in_0_wr,
  input  logic [ADDR_WIDTH-1:0] in_0_addr,
  input  logic [DATA_WIDTH-1:0] in_0_din,
  output logic [DATA_WIDTH-1:0] in_0_dout,
  output logic                  in_0_wait_n,
  output logic                  in_0_valid,
  input  logic                  in_1_rd,
  input  logic                  in_1_wr,
  input  logic [ADDR_WIDTH-1:0] in_1_addr,
  input  logic [DATA_WIDTH-1:0] in_1_din,
  output logic [DATA_WIDTH-1:0] in_1_dout,
  output logic                  in_1_wait_n,
  output logic                  in_1_valid,
  input  logic                  in_2_rd,
  input  logic                  in_2_wr,
  input  logic [ADDR_WIDTH-1:0] in_2_addr,
  input  logic [DATA_WIDTH-1:0] in_2_din,
  output logic [DATA_WIDTH-1:0] in_2_dout,
  output logic                  in_2_wait_n,
  output logic                  in_2_valid,
  output logic                  out_rd,
  output logic                  out_wr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_din,
  input  logic [DATA_WIDTH-1:0] out_dout,
  input  logic                  out_wait_n,
  input  logic                  out_valid,
  output logic                  busy,
  output logic                  timeout_err
);

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  state_e r_state, w_state_next, w_state_eff;
  logic [1:0] r_ptr, w_ptr_next, w_ptr_eff;
  logic [1:0] r_owner, w_owner_next;

  logic [2:0] w_rd, w_wr, w_req;
  logic       w_grant_vld;
  logic [1:0] w_grant, w_scan;
  logic       w_sel_rd, w_sel_wr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_din;
  logic [2:0] w_wait_n, w_valid;
  logic       w_tmo_hit;

  // Add modulo 3; operands are always in 0..2.
  function automatic logic [1:0] wrap_add(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // While reset is held, the combinational outputs behave as IDLE with ptr 0.
  assign w_state_eff = reset ? StIdle : r_state;
  assign w_ptr_eff   = reset ? 2'd0 : r_ptr;

  assign w_rd  = {in_2_rd, in_1_rd, in_0_rd};
  assign w_wr  = {in_2_wr, in_1_wr, in_0_wr};
  assign w_req = w_rd | w_wr;

  assign in_0_dout = out_dout;
  assign in_1_dout = out_dout;
  assign in_2_dout = out_dout;

  // Scan from the farthest offset down, so the offset closest to ptr wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = 2'd0;
    w_scan      = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      w_scan = wrap_add(w_ptr_eff, 2'(k));
      if (w_req[w_scan]) begin
        w_grant_vld = 1'b1;
        w_grant     = w_scan;
      end
    end
  end

  always_comb begin
    w_sel_rd   = 1'b0;
    w_sel_wr   = 1'b0;
    w_sel_addr = '0;
    w_sel_din  = '0;
    case (w_grant)
      2'd0: begin
        w_sel_rd = in_0_rd; w_sel_wr = in_0_wr; w_sel_addr = in_0_addr; w_sel_din = in_0_din;
      end
      2'd1: begin
        w_sel_rd = in_1_rd; w_sel_wr = in_1_wr; w_sel_addr = in_1_addr; w_sel_din = in_1_din;
      end
      2'd2: begin
        w_sel_rd = in_2_rd; w_sel_wr = in_2_wr; w_sel_addr = in_2_addr; w_sel_din = in_2_din;
      end
      default: ;
    endcase
  end

`ifdef ASYNC_MEM_TIMEOUT_EN
  logic [15:0] r_tmo_cnt, w_tmo_cnt_next;

  // A response on the final counted cycle completes the read normally.
  assign w_tmo_hit = (w_state_eff == StPending) && !out_valid &&
                     (r_tmo_cnt == 16'(TIMEOUT - 1));

  // The count is held at zero outside PENDING, so it starts from zero on every read.
  always_comb begin
    w_tmo_cnt_next = 16'd0;
    if ((w_state_eff == StPending) && !out_valid && !w_tmo_hit) begin
      w_tmo_cnt_next = r_tmo_cnt + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tmo_cnt <= 16'd0;
    end else begin
      r_tmo_cnt <= w_tmo_cnt_next;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^(16'(TIMEOUT));
  assign w_tmo_hit        = 1'b0;
`endif

  assign timeout_err = w_tmo_hit;

  always_comb begin
    out_rd   = 1'b0;
    out_wr   = 1'b0;
    out_addr = '0;
    out_din  = '0;
    w_wait_n = 3'b000;
    w_valid  = 3'b000;
    busy     = 1'b0;
    if (w_state_eff == StIdle) begin
      // Requesters that lose arbitration are stalled. Idle requesters mirror the memory.
      for (int n = 0; n < 3; n++) begin
        w_wait_n[n] = (w_req[n] && !(w_grant_vld && (w_grant == 2'(n)))) ? 1'b0 : out_wait_n;
      end
      if (w_grant_vld) begin
        out_rd   = w_sel_rd;
        out_wr   = w_sel_wr;
        out_addr = w_sel_addr;
        out_din  = w_sel_din;
      end
    end else begin
      busy = 1'b1;
      if (out_valid) begin
        case (r_owner)
          2'd0:    w_valid = 3'b001;
          2'd1:    w_valid = 3'b010;
          2'd2:    w_valid = 3'b100;
          default: w_valid = 3'b000;
        endcase
      end
    end
  end

  assign {in_2_wait_n, in_1_wait_n, in_0_wait_n} = w_wait_n;
  assign {in_2_valid, in_1_valid, in_0_valid}    = w_valid;

  always_comb begin
    w_state_next = w_state_eff;
    w_ptr_next   = w_ptr_eff;
    w_owner_next = r_owner;
    unique case (w_state_eff)
      StIdle: begin
        if (w_grant_vld && out_wait_n) begin
          w_ptr_next = wrap_add(w_grant, 2'd1);
          // Read and write together counts as a read; the memory decides what happens.
          if (w_sel_rd) begin
            w_owner_next = w_grant;
            w_state_next = StPending;
          end
        end
      end
      StPending: begin
        if (out_valid || w_tmo_hit) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
      r_ptr   <= 2'd0;
      r_owner <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_owner <= w_owner_next;
    end
  end

endmodule

// File: doc/async_mem_rr_scheduler.md
ASYNC_MEM_RR_SCHEDULER -- requirements
Module: async_mem_rr_scheduler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7, address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, data width of all ports.
REQ-003 SHALL have parameter TIMEOUT, default 255, max cycles a read may stay outstanding (1..65535).
REQ-004 SHALL have ports: clock  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have per requester n in {0,1,2}: in_n_rd in 1 read request; in_n_wr in 1 write request; in_n_addr in ADDR_WIDTH; in_n_din in DATA_WIDTH write data.
REQ-006 SHALL have per requester n: in_n_dout out DATA_WIDTH read data; in_n_wait_n out 1 request accepted when high; in_n_valid out 1 read data strobe.
REQ-007 SHALL have memory side: out_rd out 1; out_wr out 1; out_addr out ADDR_WIDTH; out_din out DATA_WIDTH; out_dout in DATA_WIDTH; out_wait_n in 1; out_valid in 1.
REQ-008 SHALL have status: busy out 1 read outstanding; timeout_err out 1 one-cycle pulse on read abort.

Function
REQ-009 SHALL implement states IDLE and PENDING; one read outstanding max.
REQ-010 IDLE: grant = first requesting port (rd|wr) scanning ptr, ptr+1, ptr+2 mod 3; no request -> no grant.
REQ-011 IDLE: out_rd/out_wr/out_addr/out_din = granted port's signals; all zero when no grant.
REQ-012 IDLE: granted port in_wait_n = out_wait_n; non-granted requesting ports in_wait_n = 0; idle ports in_wait_n = out_wait_n.
REQ-013 Rd and wr both high on granted port: forwarded unchanged (memory resolves); treated as read for state.
REQ-014 Acceptance = grant present and out_wait_n high in IDLE; on acceptance ptr <= (granted index + 1) mod 3.
REQ-015 Accepted write: stays IDLE; next cycle rearbitrates.
REQ-016 Accepted read: owner <= granted index; IDLE -> PENDING next edge.
REQ-017 PENDING: out_rd = out_wr = 0, address/data zero, all in_n_wait_n = 0, busy = 1.
REQ-018 PENDING with out_valid: in_owner_valid = 1 same cycle; -> IDLE next edge; new request may be accepted that following cycle.
REQ-019 out_valid in IDLE SHALL be ignored: no in_n_valid asserted.
REQ-020 in_n_dout = out_dout for all n, unconditionally.
REQ-021 ptr and owner SHALL be 2-bit, values 0..2 only; ptr wraps 2 -> 0.

Reset
REQ-022 On reset: state IDLE, ptr 0, owner 0, timeout counter 0, timeout_err 0, busy 0.
REQ-023 Reset during PENDING: abandons read; any later out_valid discarded per REQ-019.
REQ-024 Combinational outputs under reset SHALL follow IDLE rules with ptr 0.

Configuration
REQ-025 Macro ASYNC_MEM_TIMEOUT_EN SHALL compile in the read watchdog.
REQ-026 With macro: counter clears on PENDING entry, increments each PENDING cycle without out_valid; at count TIMEOUT-1 without out_valid -> IDLE next edge, timeout_err = 1 for that one cycle, no in_n_valid.
REQ-027 With macro: out_valid on the final counted cycle wins; normal completion, no timeout_err.
REQ-028 Without macro: no counter logic; timeout_err tied 0; PENDING held until out_valid or reset.

Verification
REQ-029 All three ports rd at once, out_wait_n=1, out_valid 2 cycles after each issue -> service order 0,1,2,0; only owner sees valid.
REQ-030 ptr=1, ports 0 and 2 write continuously -> order 2,0,2,0; one write per cycle, no PENDING entry.
REQ-031 Port 1 rd with out_wait_n=0 for 4 cycles -> out_rd held, in_1_wait_n=0, no PENDING until wait_n=1.
REQ-032 Read issued, reset asserted in PENDING, out_valid arrives 2 cycles after reset release -> busy 0, no in_n_valid.
REQ-033 ASYNC_MEM_TIMEOUT_EN, TIMEOUT=4, no out_valid -> timeout_err pulse on 4th PENDING cycle, IDLE after; valid on 4th cycle instead -> no pulse.
REQ-034 out_valid pulsed in IDLE with port 0 idle -> all in_n_valid stay 0, state IDLE.
